// File: rtl/dom_gf_pkg.sv
// Shared definitions for the DOM-protected GF(2^n) multiplier.
// Holds the field-arithmetic helpers and the share-pair indexing for the randomness bus.
package dom_gf_pkg;

    // Upper bound on the field degree the arithmetic helper supports.
    localparam int unsigned MAX_WIDTH = 16;
    localparam int unsigned Y_IDX_W   = $clog2(MAX_WIDTH);
    localparam int unsigned SH_IDX_W  = $clog2(MAX_WIDTH + 1);

    // Standard irreducible polynomials (MSB is x^n).
    localparam logic [2:0] GF4_POLY   = 3'b111;
    localparam logic [4:0] GF16_POLY  = 5'b10011;
    localparam logic [8:0] GF256_POLY = 9'b100011011;

    // Number of cross-domain share pairs, each needing one fresh random element.
    function automatic int unsigned npair(input int unsigned shares);
        return (shares * (shares - 1)) / 2;
    endfunction

    // Slot of pair (i,j), i<j, in the randomness bus: order (0,1),(0,2)..(1,2)..
    function automatic int unsigned pair_idx(input int unsigned i,
                                             input int unsigned j,
                                             input int unsigned shares);
        return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Carry-less product of x and y reduced modulo poly; only the low width bits are meaningful.
    function automatic logic [MAX_WIDTH-1:0] gf_mul(input logic [MAX_WIDTH-1:0] x,
                                                    input logic [MAX_WIDTH-1:0] y,
                                                    input logic [MAX_WIDTH:0]   poly,
                                                    input int unsigned          width);
        logic [MAX_WIDTH-1:0] acc;
        logic [MAX_WIDTH:0]   sh;
        logic [MAX_WIDTH:0]   mask;
        mask = (MAX_WIDTH + 1)'((33'd1 << width) - 33'd1);
        acc  = '0;
        sh   = {1'b0, x} & mask;
        for (int unsigned k = 0; k < MAX_WIDTH; k++) begin
            if (k < width) begin
                if (y[Y_IDX_W'(k)]) begin
                    acc = acc ^ sh[MAX_WIDTH-1:0];
                end
                // Multiply the running partial by x and fold the overflow back in.
                sh = sh << 1;
                if (sh[SH_IDX_W'(width)]) begin
                    sh = sh ^ poly;
                end
                sh = sh & mask;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_mult_comb.sv
// Purely combinational GF(2^WIDTH) multiplier for one share product.
module gf_mult_comb
    import dom_gf_pkg::*;
#(
    parameter int unsigned      WIDTH = 2,
    parameter logic [WIDTH:0]   POLY  = 3'b111
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] prod_c
);

    // Field product, truncated to the element width.
    assign prod_c = WIDTH'(gf_mul(MAX_WIDTH'(x_i), MAX_WIDTH'(y_i),
                                  (MAX_WIDTH + 1)'(POLY), WIDTH));

endmodule

// File: rtl/dom_gf_multiplier.sv
// Pipelined DOM-indep masked GF(2^WIDTH) multiplier with valid/ready handshake.
// All SHARES^2 share products are registered (cross terms remasked with fresh
// randomness) before compression, so no two domains meet in unregistered logic.
// Optional: define DOM_GF_UNMASK_CHECK_EN to add the debug-only err output that
// compares the recombined product against an unmasked reference.
module dom_gf_multiplier
    import dom_gf_pkg::*;
#(
    parameter  int unsigned    WIDTH  = 2,
    parameter  int unsigned    SHARES = 2,
    parameter  logic [WIDTH:0] POLY   = 3'b111,
    localparam int unsigned    NPAIR  = npair(SHARES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SHARES*WIDTH-1:0]   a_sh,
    input  logic [SHARES*WIDTH-1:0]   b_sh,
    input  logic [NPAIR*WIDTH-1:0]    z_rand,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SHARES*WIDTH-1:0]   q_sh
`ifdef DOM_GF_UNMASK_CHECK_EN
    ,
    output logic                      err
`endif
);

    localparam int unsigned NTERM = SHARES * SHARES;

    logic                              accept;
    logic                              valid_q;
    logic [NTERM-1:0][WIDTH-1:0]       term_d;
    logic [NTERM-1:0][WIDTH-1:0]       term_q;
    logic [SHARES-1:0][WIDTH-1:0]      q_c;

    assign in_ready  = ~valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_q;

    // Stage 1: one multiplier per (i,j) share pair; cross terms remasked with z_ij.
    for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
        for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
            localparam int unsigned PI = (gi < gj) ? pair_idx(gi, gj, SHARES) :
                                         (gi > gj) ? pair_idx(gj, gi, SHARES) : 0;
            logic [WIDTH-1:0] prod;

            gf_mult_comb #(
                .WIDTH (WIDTH),
                .POLY  (POLY)
            ) u_mul (
                .x_i    (a_sh[gi*WIDTH +: WIDTH]),
                .y_i    (b_sh[gj*WIDTH +: WIDTH]),
                .prod_c (prod)
            );

            if (gi == gj) begin : g_inner
                assign term_d[gi*SHARES + gj] = prod;
            end else begin : g_cross
                assign term_d[gi*SHARES + gj] = prod ^ z_rand[PI*WIDTH +: WIDTH];
            end
        end
    end

    // Term bank and output-valid flag; the bank loads only on accept, so a stall holds q_sh.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            term_q  <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            term_q  <= term_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Stage 2: each output share compresses its own row of registered terms.
    always_comb begin
        q_c = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                q_c[i] = q_c[i] ^ term_q[i*SHARES + j];
            end
        end
    end

    assign q_sh = q_c;

`ifdef DOM_GF_UNMASK_CHECK_EN
    logic [WIDTH-1:0] a_all_c;
    logic [WIDTH-1:0] b_all_c;
    logic [WIDTH-1:0] q_all_c;
    logic [WIDTH-1:0] ref_d;
    logic [WIDTH-1:0] ref_q;

    // Debug-only recombination of operands and product; deliberately unmasked.
    always_comb begin
        a_all_c = '0;
        b_all_c = '0;
        q_all_c = '0;
        for (int i = 0; i < SHARES; i++) begin
            a_all_c = a_all_c ^ a_sh[i*WIDTH +: WIDTH];
            b_all_c = b_all_c ^ b_sh[i*WIDTH +: WIDTH];
            q_all_c = q_all_c ^ q_c[i];
        end
    end

    gf_mult_comb #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_ref_mul (
        .x_i    (a_all_c),
        .y_i    (b_all_c),
        .prod_c (ref_d)
    );

    // Unmasked reference product, captured alongside the term bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q <= '0;
        end else if (accept) begin
            ref_q <= ref_d;
        end
    end

    assign err = valid_q & (q_all_c != ref_q);
`endif

endmodule

// File: tb/tb_dom_gf_multiplier.sv
// Scoreboard bench for dom_gf_multiplier: a GF(4)/2-share instance for handshake
// and directed cases, and a GF(16)/3-share instance swept over all operand pairs.
module tb_dom_gf_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // GF(4), 2 shares
    logic        d2_in_valid = 1'b0;
    logic        d2_in_ready;
    logic [3:0]  d2_a = '0;
    logic [3:0]  d2_b = '0;
    logic [1:0]  d2_z = '0;
    logic        d2_out_valid;
    logic        d2_out_ready = 1'b0;
    logic [3:0]  d2_q;
    // GF(16), 3 shares
    logic        d4_in_valid = 1'b0;
    logic        d4_in_ready;
    logic [11:0] d4_a = '0;
    logic [11:0] d4_b = '0;
    logic [11:0] d4_z = '0;
    logic        d4_out_valid;
    logic        d4_out_ready = 1'b0;
    logic [11:0] d4_q;
`ifdef DOM_GF_UNMASK_CHECK_EN
    logic        d2_err;
    logic        d4_err;
`endif

    int          q2[$];
    int          q4[$];
    logic [3:0]  last_q2;

    dom_gf_multiplier #(.WIDTH(2), .SHARES(2), .POLY(3'b111)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .a_sh      (d2_a),
        .b_sh      (d2_b),
        .z_rand    (d2_z),
        .out_valid (d2_out_valid),
        .out_ready (d2_out_ready),
        .q_sh      (d2_q)
`ifdef DOM_GF_UNMASK_CHECK_EN
        ,
        .err       (d2_err)
`endif
    );

    dom_gf_multiplier #(.WIDTH(4), .SHARES(3), .POLY(5'b10011)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d4_in_valid),
        .in_ready  (d4_in_ready),
        .a_sh      (d4_a),
        .b_sh      (d4_b),
        .z_rand    (d4_z),
        .out_valid (d4_out_valid),
        .out_ready (d4_out_ready),
        .q_sh      (d4_q)
`ifdef DOM_GF_UNMASK_CHECK_EN
        ,
        .err       (d4_err)
`endif
    );

    // Reference field product via discrete log / antilog tables (x is primitive for both fields).
    function automatic int ref_mul(input int a, input int b, input int w, input int poly);
        int exp_t[256];
        int log_t[256];
        int order;
        int e;
        order = (1 << w) - 1;
        e = 1;
        for (int k = 0; k < order; k++) begin
            exp_t[k] = e;
            log_t[e] = k;
            e = e << 1;
            if ((e & (1 << w)) != 0) e = e ^ poly;
        end
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % order];
    endfunction

    function automatic int xor2(input logic [3:0] q);
        return int'(q[1:0] ^ q[3:2]);
    endfunction

    function automatic int xor4(input logic [11:0] q);
        return int'(q[3:0] ^ q[7:4] ^ q[11:8]);
    endfunction

    // Expected 2-share DOM output shares: q_i = a_i*b_i ^ a_i*b_j ^ z.
    function automatic int dom2(input logic [3:0] a, input logic [3:0] b, input logic [1:0] z);
        int s0;
        int s1;
        s0 = ref_mul(a[1:0], b[1:0], 2, 7) ^ ref_mul(a[1:0], b[3:2], 2, 7) ^ z;
        s1 = ref_mul(a[3:2], b[3:2], 2, 7) ^ ref_mul(a[3:2], b[1:0], 2, 7) ^ z;
        return (s1 << 2) | s0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One cycle of GF(4) stimulus; pushes the expected product when the model says it is accepted.
    task automatic step2(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] z, input logic ordy);
        bit exp_rdy;
        @(posedge clk);
        #1;
        last_q2 = d2_q;
        check("d2 out_valid", int'(d2_out_valid), int'(q2.size() != 0));
        rst          = r;
        d2_in_valid  = v;
        d2_a         = a;
        d2_b         = b;
        d2_z         = z;
        d2_out_ready = ordy;
        if (r) begin
            q2.delete();
            q4.delete();
        end
        exp_rdy = (q2.size() == 0) || ordy;
        @(negedge clk);
        if (!r) begin
            check("d2 in_ready", int'(d2_in_ready), int'(exp_rdy));
            if (v && exp_rdy) q2.push_back(ref_mul(int'(a[1:0] ^ a[3:2]), int'(b[1:0] ^ b[3:2]), 2, 7));
        end
    endtask

    task automatic step4(input logic v, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] z, input logic ordy, output bit acc);
        bit exp_rdy;
        @(posedge clk);
        #1;
        check("d4 out_valid", int'(d4_out_valid), int'(q4.size() != 0));
        d4_in_valid  = v;
        d4_a         = a;
        d4_b         = b;
        d4_z         = z;
        d4_out_ready = ordy;
        exp_rdy = (q4.size() == 0) || ordy;
        @(negedge clk);
        check("d4 in_ready", int'(d4_in_ready), int'(exp_rdy));
        acc = v && exp_rdy;
        if (acc) q4.push_back(ref_mul(xor4(a), xor4(b), 4, 19));
    endtask

    // Scoreboard monitors: pop and compare on every handshake-completed product.
    always @(negedge clk) begin
        if (!rst && d2_out_valid === 1'b1 && d2_out_ready === 1'b1) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d2 unexpected product: got %0d want none", xor2(d2_q));
            end else begin
                check("d2 product", xor2(d2_q), q2.pop_front());
            end
        end
`ifdef DOM_GF_UNMASK_CHECK_EN
        if (!rst && d2_out_valid === 1'b1) check("d2 err", int'(d2_err), 0);
`endif
    end

    always @(negedge clk) begin
        if (!rst && d4_out_valid === 1'b1 && d4_out_ready === 1'b1) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d4 unexpected product: got %0d want none", xor4(d4_q));
            end else begin
                check("d4 product", xor4(d4_q), q4.pop_front());
            end
        end
`ifdef DOM_GF_UNMASK_CHECK_EN
        if (!rst && d4_out_valid === 1'b1) check("d4 err", int'(d4_err), 0);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  ax;
        logic [3:0]  bx;
        logic [1:0]  zx;
        int          s1;
        bit          acc;
        int          tries;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [11:0] a4;
        logic [11:0] b4;

        // Reset held for two cycles, then idle checks
        repeat (2) @(posedge clk);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        check("reset q_sh", int'(last_q2), 0);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);

        // A=2 (1/3), B=3 (2/1), z=1 then z=2
        step2(1'b0, 1'b1, 4'b1101, 4'b0110, 2'd1, 1'b1);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        check("shares z1", int'(last_q2), dom2(4'b1101, 4'b0110, 2'd1));
        s1 = int'(last_q2);
        step2(1'b0, 1'b1, 4'b1101, 4'b0110, 2'd2, 1'b1);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        check("shares z2", int'(last_q2), dom2(4'b1101, 4'b0110, 2'd2));
        check("shares differ", int'(int'(last_q2) != s1), 1);

        // Back-to-back 2*2, 3*3, 3*1
        step2(1'b0, 1'b1, 4'b0111, 4'b1000, 2'd3, 1'b1);
        step2(1'b0, 1'b1, 4'b1100, 4'b0011, 2'd1, 1'b1);
        step2(1'b0, 1'b1, 4'b0110, 4'b1110, 2'd0, 1'b1);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);

        // Stall three cycles with new operands offered, then drain and accept together
        ax = 4'($urandom); bx = 4'($urandom); zx = 2'($urandom);
        step2(1'b0, 1'b1, ax, bx, zx, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step2(1'b0, 1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
            check("stall hold", int'(last_q2), dom2(ax, bx, zx));
        end
        step2(1'b0, 1'b1, 4'b1001, 4'b1011, 2'd2, 1'b1);
        check("stall hold end", int'(last_q2), dom2(ax, bx, zx));
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);

        // Mid-op reset discards the pending product
        step2(1'b0, 1'b1, 4'b0110, 4'b1011, 2'd1, 1'b1);
        step2(1'b1, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        check("mid reset q_sh", int'(last_q2), 0);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);

        // Random traffic with random backpressure
        for (int k = 0; k < 150; k++) begin
            step2(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
        repeat (3) step2(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        check("d2 drained", q2.size(), 0);

        // GF(16), 3 shares: every operand pair with random shares and randomness
        for (int A = 0; A < 16; A++) begin
            for (int B = 0; B < 16; B++) begin
                r0 = 4'($urandom); r1 = 4'($urandom);
                a4 = {4'(A) ^ r0 ^ r1, r1, r0};
                r0 = 4'($urandom); r1 = 4'($urandom);
                b4 = {4'(B) ^ r0 ^ r1, r1, r0};
                acc = 1'b0;
                tries = 0;
                while (!acc && tries < 40) begin
                    step4(1'b1, a4, b4, 12'($urandom), 1'($urandom_range(0, 3) != 0), acc);
                    tries++;
                end
                if (!acc) begin
                    total++;
                    bad++;
                    $display("FAIL d4 accept: got none want accept within 40 cycles");
                end
            end
        end
        repeat (3) step4(1'b0, 12'h0, 12'h0, 12'h0, 1'b1, acc);
        check("d4 drained", q4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
